// File: rtl/subparser_num_arg.sv
// Signed decimal integer argument subparser: pulls characters from the shared
// reader on trigger and reports done/success/newline plus the parsed value.
module subparser_num_arg #(
    parameter int MAX_DIGITS  = 5,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    output logic                   rdy,
    output logic                   done,
    output logic                   success,
    output logic                   newline,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   rd_trigger,
    input  logic                   rd_rdy,
    input  logic                   rd_done,
    input  logic [7:0]             rd_data,
    input  logic                   is_empty
);

    function automatic int min_width(input int digits);
        longint unsigned p;
        int              b;
        p = 1;
        b = 0;
        for (int i = 0; i < digits; i++) p = p * 10;
        while ((64'd1 << b) < p) b++;
        return b + 1;
    endfunction

    localparam int MIN_W = min_width(MAX_DIGITS);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    generate
        if (VALUE_WIDTH < MIN_W) begin : g_width_check
            $error("VALUE_WIDTH too small for MAX_DIGITS");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, PROC, DONE} state_t;
    typedef enum logic [1:0] {LEAD, SIGNED, DIGITS} phase_t;

    state_t                 state;
    phase_t                 phase;
    logic [VALUE_WIDTH-1:0] acc;
    logic [CNT_W-1:0]       cnt;
    logic                   neg;
    logic [7:0]             ch_q;

    logic is_digit, is_ws, is_nl, is_sign;
    logic fin, fin_ok, fin_nl, do_acc, set_signed, to_check;
    logic [VALUE_WIDTH-1:0] acc_next;

    assign is_digit = (ch_q >= 8'h30) && (ch_q <= 8'h39);
    assign is_ws    = (ch_q == 8'h20) || (ch_q == 8'h0d);
    assign is_nl    = (ch_q == 8'h0a);
    assign is_sign  = (ch_q == 8'h2b) || (ch_q == 8'h2d);
    // Digit value is the low nibble of an ASCII '0'..'9'.
    assign acc_next = acc * VALUE_WIDTH'(10) + VALUE_WIDTH'(ch_q[3:0]);

    always_comb begin
        fin        = 1'b0;
        fin_ok     = 1'b0;
        fin_nl     = 1'b0;
        do_acc     = 1'b0;
        set_signed = 1'b0;
        to_check   = 1'b0;
        case (state)
            CHECK: begin
                if (is_empty) begin
                    fin    = 1'b1;
                    fin_ok = (cnt != '0);
                end
            end
            PROC: begin
                case (phase)
                    LEAD: begin
                        if (is_ws) to_check = 1'b1;
                        else if (is_sign) begin
                            set_signed = 1'b1;
                            to_check   = 1'b1;
                        end else if (is_digit) begin
                            do_acc   = 1'b1;
                            to_check = 1'b1;
                        end else begin
                            fin    = 1'b1;
                            fin_nl = is_nl;
                        end
                    end
                    SIGNED: begin
                        if (is_digit) begin
                            do_acc   = 1'b1;
                            to_check = 1'b1;
                        end else begin
                            fin    = 1'b1;
                            fin_nl = is_nl;
                        end
                    end
                    default: begin
                        if (is_digit && (cnt < CNT_W'(MAX_DIGITS))) begin
                            do_acc   = 1'b1;
                            to_check = 1'b1;
                        end else begin
                            fin    = 1'b1;
                            fin_ok = is_ws || is_nl;
                            fin_nl = is_nl;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= LEAD;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            ch_q       <= '0;
            rdy        <= 1'b1;
            done       <= 1'b0;
            rd_trigger <= 1'b0;
            success    <= 1'b0;
            newline    <= 1'b0;
            value      <= '0;
        end else begin
            done       <= 1'b0;
            rd_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        acc   <= '0;
                        cnt   <= '0;
                        neg   <= 1'b0;
                        phase <= LEAD;
                        rdy   <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!fin && rd_rdy) begin
                        rd_trigger <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (rd_done) begin
                        ch_q  <= rd_data;
                        state <= PROC;
                    end
                end
                PROC: begin
                    if (do_acc) begin
                        acc   <= acc_next;
                        cnt   <= cnt + 1'b1;
                        phase <= DIGITS;
                    end
                    if (set_signed) begin
                        neg   <= (ch_q == 8'h2d);
                        phase <= SIGNED;
                    end
                    if (to_check) state <= CHECK;
                end
                DONE: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Shared finish path for CHECK (reader empty) and PROC (terminator/error).
            if (fin) begin
                state   <= DONE;
                done    <= 1'b1;
                success <= fin_ok;
                newline <= fin_nl;
                value   <= fin_ok ? (neg ? (~acc + VALUE_WIDTH'(1)) : acc) : '0;
            end
        end
    end

endmodule

// File: tb/tb_subparser_num_arg.sv
// Directed bench for subparser_num_arg with a zero-wait string-fed reader model.
module tb_subparser_num_arg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic        rdy, done, success, newline, rd_trigger;
    logic [31:0] value;
    logic        rd_rdy = 1'b1;
    logic        rd_done;
    logic [7:0]  rd_data;
    logic        is_empty;

    int checks = 0;
    int failures = 0;

    string rd_str = "";
    int    rd_idx = 0;
    int    trig_cnt = 0;

    always #5 clk = ~clk;

    subparser_num_arg #(.MAX_DIGITS(5), .VALUE_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .rdy(rdy), .done(done),
        .success(success), .newline(newline), .value(value),
        .rd_trigger(rd_trigger), .rd_rdy(rd_rdy), .rd_done(rd_done),
        .rd_data(rd_data), .is_empty(is_empty)
    );

    assign is_empty = (rd_idx >= rd_str.len());

    // Reader answers a request with rd_done in the very next cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_done <= 1'b0;
            rd_data <= 8'h00;
        end else if (rd_trigger) begin
            rd_done  <= 1'b1;
            rd_data  <= (rd_idx < rd_str.len()) ? rd_str[rd_idx] : 8'h00;
            rd_idx   <= rd_idx + 1;
            trig_cnt <= trig_cnt + 1;
        end else begin
            rd_done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input string s);
        @(negedge clk);
        rd_str   = s;
        rd_idx   = 0;
        trig_cnt = 0;
        trigger  = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    // lat counts cycles after the trigger edge until done is visible.
    task automatic wait_done(output logic seen, output int lat);
        seen = 1'b0;
        lat  = 1;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input string s, input logic exp_ok,
                       input logic exp_nl, input logic [31:0] exp_val, input int exp_trig);
        logic seen;
        int   lat;
        start(s);
        wait_done(seen, lat);
        chk({tag, "_done"}, seen, 1'b1);
        chk({tag, "_success"}, success, exp_ok);
        chk({tag, "_newline"}, newline, exp_nl);
        chk({tag, "_value"}, value, exp_val);
        chk({tag, "_rdtrig"}, trig_cnt, exp_trig);
    endtask

    initial begin
        logic seen;
        int   lat;

        #12;
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_rdtrig", rd_trigger, 1'b0);
        chk("rst_success", success, 1'b0);
        chk("rst_newline", newline, 1'b0);
        chk("rst_value", value, 32'd0);
        reset = 1'b1;

        // Leading space, digits, space terminator; rdy returns one cycle after done.
        start(" 123 ");
        chk("busy_rdy", rdy, 1'b0);
        wait_done(seen, lat);
        chk("s123_done", seen, 1'b1);
        chk("s123_success", success, 1'b1);
        chk("s123_newline", newline, 1'b0);
        chk("s123_value", value, 32'd123);
        chk("s123_rdtrig", trig_cnt, 5);
        @(negedge clk);
        chk("s123_rdy_after", rdy, 1'b1);
        chk("s123_done_pulse", done, 1'b0);

        run("neg42", "-42\n", 1'b1, 1'b1, 32'hFFFF_FFD6, 4);
        run("bad12a", "12a", 1'b0, 1'b0, 32'd0, 3);
        run("nl_only", "\n", 1'b0, 1'b1, 32'd0, 1);
        run("sign_nl", "-\n", 1'b0, 1'b1, 32'd0, 2);
        run("eof7", "7", 1'b1, 1'b0, 32'd7, 1);
        run("empty", "", 1'b0, 1'b0, 32'd0, 0);
        run("ovf6", "123456", 1'b0, 1'b0, 32'd0, 6);
        run("max5", "+12345 ", 1'b1, 1'b0, 32'd12345, 7);
        run("sign_sp", "- 5", 1'b0, 1'b0, 32'd0, 2);

        // Two characters at 4 cycles each plus DONE: 9 cycles after the trigger edge.
        start("7 ");
        wait_done(seen, lat);
        chk("lat7_value", value, 32'd7);
        chk("lat7_cycles", lat, 9);

        // Reader not ready: no request may go out while rd_rdy is low.
        rd_rdy = 1'b0;
        start("8 ");
        repeat (10) @(negedge clk);
        chk("stall_rdtrig", trig_cnt, 0);
        chk("stall_rdy", rdy, 1'b0);
        rd_rdy = 1'b1;
        wait_done(seen, lat);
        chk("stall_done", seen, 1'b1);
        chk("stall_value", value, 32'd8);
        chk("stall_rdtrig_after", trig_cnt, 2);

        // Reset while waiting on the second character of "-99 ".
        start("-99 ");
        for (int i = 0; i < 50 && trig_cnt < 2; i++) @(negedge clk);
        chk("midrst_reached", trig_cnt, 2);
        reset = 1'b0;
        #1;
        chk("midrst_rdy", rdy, 1'b1);
        chk("midrst_rdtrig", rd_trigger, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run("post_rst5", "5 ", 1'b1, 1'b0, 32'd5, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
